// File: rtl/conv_pe_engine_if.sv
// rtl/conv_pe_engine_if.sv - operand, result and status bundle for conv_pe_engine
interface conv_pe_engine_if #(parameter int DW = 8);
    logic          start;
    logic [DW-1:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [DW-1:0] a31, a32, a33, a34, a41, a42, a43, a44;
    logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic [DW-1:0] out;
    logic          we_pe_1, we_pe_2, we_pe_3, we_pe_4;
    logic          busy, done, sat;

    modport master (
        output start,
        output a11, a12, a13, a14, a21, a22, a23, a24,
        output a31, a32, a33, a34, a41, a42, a43, a44,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33,
        input  out, we_pe_1, we_pe_2, we_pe_3, we_pe_4, busy, done, sat
    );

    modport slave (
        input  start,
        input  a11, a12, a13, a14, a21, a22, a23, a24,
        input  a31, a32, a33, a34, a41, a42, a43, a44,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33,
        output out, we_pe_1, we_pe_2, we_pe_3, we_pe_4, busy, done, sat
    );
endinterface

// File: rtl/conv_pe_engine.sv
// rtl/conv_pe_engine.sv - single-MAC 4x4 by 3x3 valid convolution into four PE result RAMs
module conv_pe_engine #(
    parameter int DW   = 8,
    parameter int ACCW = 2 * DW + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_pe_engine_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    localparam logic [ACCW-1:0] MAXV = ACCW'((64'd1 << DW) - 64'd1);

    state_t        state;
    logic [DW-1:0] a_in [4][4];
    logic [DW-1:0] b_in [3][3];
    logic [DW-1:0] a_q  [4][4];
    logic [DW-1:0] b_q  [3][3];
    logic [1:0]    o;
    logic [1:0]    ti, tj;
    logic [ACCW-1:0] acc;
    logic [DW-1:0] out_q;
    logic [3:0]    we_q;
    logic          busy_q, done_q, sat_q;

    assign a_in[0][0] = bus.a11; assign a_in[0][1] = bus.a12;
    assign a_in[0][2] = bus.a13; assign a_in[0][3] = bus.a14;
    assign a_in[1][0] = bus.a21; assign a_in[1][1] = bus.a22;
    assign a_in[1][2] = bus.a23; assign a_in[1][3] = bus.a24;
    assign a_in[2][0] = bus.a31; assign a_in[2][1] = bus.a32;
    assign a_in[2][2] = bus.a33; assign a_in[2][3] = bus.a34;
    assign a_in[3][0] = bus.a41; assign a_in[3][1] = bus.a42;
    assign a_in[3][2] = bus.a43; assign a_in[3][3] = bus.a44;
    assign b_in[0][0] = bus.b11; assign b_in[0][1] = bus.b12;
    assign b_in[0][2] = bus.b13; assign b_in[1][0] = bus.b21;
    assign b_in[1][1] = bus.b22; assign b_in[1][2] = bus.b23;
    assign b_in[2][0] = bus.b31; assign b_in[2][1] = bus.b32;
    assign b_in[2][2] = bus.b33;

    assign bus.out     = out_q;
    assign bus.we_pe_1 = we_q[0];
    assign bus.we_pe_2 = we_q[1];
    assign bus.we_pe_3 = we_q[2];
    assign bus.we_pe_4 = we_q[3];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sat     = sat_q;

    // Output o selects the window origin: row offset o[1], column offset o[0].
    logic [1:0]      ar, ac;
    logic [2*DW-1:0] prod;
    logic [ACCW-1:0] sum;
    logic            last_tap;

    assign ar       = ti + {1'b0, o[1]};
    assign ac       = tj + {1'b0, o[0]};
    assign prod     = a_q[ar][ac] * b_q[ti][tj];
    assign sum      = ((ti == 2'd0 && tj == 2'd0) ? '0 : acc) + ACCW'(prod);
    assign last_tap = (ti == 2'd2) && (tj == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            o      <= '0;
            ti     <= '0;
            tj     <= '0;
            acc    <= '0;
            out_q  <= '0;
            we_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    a_q[i][j] <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    b_q[i][j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= a_in;
                        b_q    <= b_in;
                        sat_q  <= 1'b0;
                        o      <= '0;
                        ti     <= '0;
                        tj     <= '0;
                        busy_q <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (last_tap) begin
                        out_q <= (sum > MAXV) ? {DW{1'b1}} : sum[DW-1:0];
                        we_q  <= 4'b0001 << o;
                        if (sum > MAXV)
                            sat_q <= 1'b1;
                        state <= WRITE;
                    end else if (tj == 2'd2) begin
                        tj <= '0;
                        ti <= ti + 2'd1;
                    end else begin
                        tj <= tj + 2'd1;
                    end
                end
                WRITE: begin
                    we_q <= '0;
                    ti   <= '0;
                    tj   <= '0;
                    if (o != 2'd3) begin
                        o     <= o + 2'd1;
                        state <= MAC;
                    end else begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    o      <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_pe_engine.sv
// tb/tb_conv_pe_engine.sv - randomized and directed checks of conv_pe_engine against a convolution model
module tb_conv_pe_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_pe_engine_if #(.DW(8)) bus ();
    conv_pe_engine #(.DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_assert = 0;
    int n_fail   = 0;
    int ma [4][4];
    int mb [3][3];
    int exp_c [4];
    bit ovf [4];
    int prev_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive_ops();
        bus.a11 = 8'(ma[0][0]); bus.a12 = 8'(ma[0][1]); bus.a13 = 8'(ma[0][2]); bus.a14 = 8'(ma[0][3]);
        bus.a21 = 8'(ma[1][0]); bus.a22 = 8'(ma[1][1]); bus.a23 = 8'(ma[1][2]); bus.a24 = 8'(ma[1][3]);
        bus.a31 = 8'(ma[2][0]); bus.a32 = 8'(ma[2][1]); bus.a33 = 8'(ma[2][2]); bus.a34 = 8'(ma[2][3]);
        bus.a41 = 8'(ma[3][0]); bus.a42 = 8'(ma[3][1]); bus.a43 = 8'(ma[3][2]); bus.a44 = 8'(ma[3][3]);
        bus.b11 = 8'(mb[0][0]); bus.b12 = 8'(mb[0][1]); bus.b13 = 8'(mb[0][2]);
        bus.b21 = 8'(mb[1][0]); bus.b22 = 8'(mb[1][1]); bus.b23 = 8'(mb[1][2]);
        bus.b31 = 8'(mb[2][0]); bus.b32 = 8'(mb[2][1]); bus.b33 = 8'(mb[2][2]);
    endtask

    task automatic fill(input int amax, input int bmax);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                ma[i][j] = $urandom_range(amax, 0);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                mb[i][j] = $urandom_range(bmax, 0);
    endtask

    // Valid-mode 2x2 result of the 4x4 by 3x3 convolution, clamped to 8 bits.
    task automatic model();
        for (int o = 0; o < 4; o++) begin
            int s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s += ma[i + o / 2][j + o % 2] * mb[i][j];
            ovf[o]   = (s > 255);
            exp_c[o] = (s > 255) ? 255 : s;
        end
    endtask

    function automatic logic [3:0] we_vec();
        return {bus.we_pe_4, bus.we_pe_3, bus.we_pe_2, bus.we_pe_1};
    endfunction

    // One full run; optional start re-pulse and operand change mid-run.
    task automatic do_run(input string tag, input int restart_cycle, input int change_cycle);
        bit exp_sat = 0;
        model();
        drive_ops();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 45; n++) begin
            int wo;
            @(negedge clk);
            bus.start = (n == restart_cycle);
            wo = (n % 10 == 0 && n <= 40) ? n / 10 - 1 : -1;
            if (wo >= 0) begin
                prev_out = exp_c[wo];
                exp_sat  = exp_sat | ovf[wo];
            end
            chk({tag, "_we"}, 32'(we_vec()), (wo >= 0) ? 32'(1 << wo) : 32'd0);
            chk({tag, "_out"}, 32'(bus.out), 32'(prev_out));
            chk({tag, "_done"}, 32'(bus.done), 32'(n == 41));
            chk({tag, "_busy"}, 32'(bus.busy), 32'(n <= 41));
            chk({tag, "_sat"}, 32'(bus.sat), 32'(exp_sat));
            if (n == change_cycle) begin
                fill(255, 255);
                drive_ops();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        fill(0, 0);
        drive_ops();
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_we", 32'(we_vec()), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sat", 32'(bus.sat), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ma[i][j] = 1;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mb[i][j] = 1;
        do_run("ones", 0, 0);

        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ma[i][j] = 4 * i + j + 1;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mb[i][j] = (i == 1 && j == 1);
        do_run("ident", 0, 0);

        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ma[i][j] = 255;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mb[i][j] = 255;
        do_run("max", 0, 0);

        fill(20, 3);
        do_run("restart", 15, 5);

        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) fill(15, 3); else fill(255, 255);
            do_run("rand", 0, 0);
        end

        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ma[i][j] = 255;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mb[i][j] = 255;
        drive_ops();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_we", 32'(we_vec()), 32'd0);
        chk("mrst_out", 32'(bus.out), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_sat", 32'(bus.sat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_out = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            chk("post_we", 32'(we_vec()), 32'd0);
            chk("post_busy", 32'(bus.busy), 32'd0);
            chk("post_done", 32'(bus.done), 32'd0);
        end

        fill(10, 3);
        model();
        drive_ops();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            int p, wo;
            @(negedge clk);
            p  = (n - 1) % 42 + 1;
            wo = (p % 10 == 0 && p <= 40) ? p / 10 - 1 : -1;
            if (wo >= 0) prev_out = exp_c[wo];
            chk("hold_done", 32'(bus.done), 32'(n == 41 || n == 83));
            chk("hold_we", 32'(we_vec()), (wo >= 0) ? 32'(1 << wo) : 32'd0);
            chk("hold_out", 32'(bus.out), 32'(prev_out));
        end
        bus.start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
